// File: rtl/mem_bist.sv
// mem_bist: bus-initiator memory self-test; writes addr^seed over a word range,
// reads it back, and reports pass/timeout, error count and first failing address.
module mem_bist #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [19:0] word_count,
  input  logic [31:0] seed,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] fail_addr
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;
  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d, a_q, a_d, seed_q, seed_d, fail_q, fail_d;
  logic [19:0]   wc_q, wc_d, rem_q, rem_d;
  logic [15:0]   err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d, pass_q, pass_d;
  logic          rd_q, wr_q, busy_q, done_q;
  logic [31:0]   addr_q, wdata_q;
  logic          expired, last, mism;

  assign expired = cnt_q == TW'(TIMEOUT - 1);
  assign last    = rem_q == 20'd1;
  assign mism    = mem_read_data != (a_q ^ seed_q);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    a_d     = a_q;
    seed_d  = seed_q;
    fail_d  = fail_q;
    wc_d    = wc_q;
    rem_d   = rem_q;
    err_d   = err_q;
    cnt_d   = '0;
    to_d    = to_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        base_d  = {base_addr[31:2], 2'b00};
        a_d     = {base_addr[31:2], 2'b00};
        seed_d  = seed;
        wc_d    = word_count;
        rem_d   = word_count;
        err_d   = '0;
        fail_d  = '0;
        to_d    = 1'b0;
        pass_d  = word_count == '0;
        state_d = (word_count == '0) ? DONE : WR_REQ;
      end
      WR_REQ, RD_REQ: if (mem_ack) begin
        state_d = (state_q == WR_REQ) ? WR_GAP : RD_GAP;
        if (state_q == RD_REQ && mism) begin
          err_d  = (&err_q) ? err_q : err_q + 16'd1;
          fail_d = (err_q == '0) ? a_q : fail_q;
        end
      end else if (expired) begin
        state_d = DONE;
        to_d    = 1'b1;
        pass_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      WR_GAP, RD_GAP: begin
        // the write pass ends by rewinding to base for the read-back pass
        a_d     = (last && state_q == WR_GAP) ? base_q : a_q + 32'd4;
        rem_d   = (last && state_q == WR_GAP) ? wc_q : rem_q - 20'd1;
        state_d = !last ? ((state_q == WR_GAP) ? WR_REQ : RD_REQ)
                        : ((state_q == WR_GAP) ? RD_REQ : DONE);
        pass_d  = (last && state_q == RD_GAP) ? (err_q == '0 && !to_q) : pass_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      a_q     <= '0;
      seed_q  <= '0;
      fail_q  <= '0;
      wc_q    <= '0;
      rem_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      a_q     <= a_d;
      seed_q  <= seed_d;
      fail_q  <= fail_d;
      wc_q    <= wc_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      rd_q    <= state_d == RD_REQ;
      wr_q    <= state_d == WR_REQ;
      addr_q  <= (state_d == WR_REQ || state_d == RD_REQ) ? a_d : '0;
      wdata_q <= (state_d == WR_REQ) ? (a_d ^ seed_d) : '0;
      busy_q  <= !(state_d == IDLE || state_d == DONE);
      done_q  <= state_d == DONE;
    end
  end

  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = to_q;
  assign err_count      = err_q;
  assign fail_addr      = fail_q;
endmodule
